key_param_ctrl: RTL and testbench

KEY_PARAM_CTRL -- requirements
Module: key_param_ctrl

---
 rtl/key_param_ctrl.sv | 173 +++++++++++++++++
 tb/tb_key_param_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_param_ctrl.sv
// Debounced multi-key parameter stepper: each key channel syncs, debounces, pulses on
// press and steps a wrapping parameter. Define KEY_REPEAT_EN to compile in auto-repeat.

module key_param_chan #(
   parameter int PARAM_W      = 11,
   parameter int PARAM_MAX    = 100,
   parameter int DEBOUNCE_CYC = 4
`ifdef KEY_REPEAT_EN
   ,
   parameter int HOLD_CYC     = 16,
   parameter int REPEAT_CYC   = 4
`endif
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               key_raw,
   output logic               key_level,
   output logic               key_pulse,
   output logic [PARAM_W-1:0] param
);
   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [PARAM_W-1:0] PMAX    = PARAM_W'(PARAM_MAX);

   typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} state_t;

   logic [1:0]      sync_q;
   logic            key_s;
   logic [DB_W-1:0] db_cnt;
   state_t          state, state_nxt;
   logic            fire;
   logic [PARAM_W-1:0] param_nxt;

`ifdef KEY_REPEAT_EN
   localparam int RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
   localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYC - 1);
   localparam logic [RP_W-1:0] RPT_LAST  = RP_W'(REPEAT_CYC - 1);
   logic [RP_W-1:0] rpt_cnt, rpt_nxt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[0], key_raw};
   end
   assign key_s = sync_q[1];

   // Counter only runs while the synced input disagrees with the accepted level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt    <= '0;
         key_level <= 1'b0;
      end else if (key_s == key_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         key_level <= ~key_level;
         db_cnt    <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign param_nxt = (param >= PMAX) ? '0 : param + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         key_pulse <= 1'b0;
         param     <= '0;
`ifdef KEY_REPEAT_EN
         rpt_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         key_pulse <= fire;
         if (fire) param <= param_nxt;
`ifdef KEY_REPEAT_EN
         rpt_cnt   <= rpt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_nxt   = rpt_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (key_level) begin
               state_nxt = ST_PRESSED;
               fire      = 1'b1;
`ifdef KEY_REPEAT_EN
               rpt_nxt   = '0;
`endif
            end
         end
         ST_PRESSED: begin
            if (!key_level) state_nxt = ST_IDLE;
`ifdef KEY_REPEAT_EN
            else if (rpt_cnt == HOLD_LAST) begin
               state_nxt = ST_REPEAT;
               fire      = 1'b1;
               rpt_nxt   = '0;
            end else rpt_nxt = rpt_cnt + 1'b1;
`endif
         end
         ST_REPEAT: begin
`ifdef KEY_REPEAT_EN
            if (!key_level) state_nxt = ST_IDLE;
            else if (rpt_cnt == RPT_LAST) begin
               fire    = 1'b1;
               rpt_nxt = '0;
            end else rpt_nxt = rpt_cnt + 1'b1;
`else
            state_nxt = ST_IDLE;
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule

module key_param_ctrl #(
   parameter int KEY_NUM      = 5,
   parameter int PARAM_W      = 11,
   parameter int PARAM_MAX    = 100,
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLD_CYC     = 16,
   parameter int REPEAT_CYC   = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [KEY_NUM-1:0]         key_in,
   output logic [KEY_NUM-1:0]         key_level,
   output logic [KEY_NUM-1:0]         key_pulse,
   output logic [KEY_NUM*PARAM_W-1:0] param_bus
);
   logic [KEY_NUM-1:0][PARAM_W-1:0] param_arr;

   if (PARAM_MAX < 1 || PARAM_MAX > (2**PARAM_W) - 1) begin : g_bad_max
      $error("PARAM_MAX out of range for PARAM_W");
   end
   if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 65536) begin : g_bad_db
      $error("DEBOUNCE_CYC out of range");
   end
   if (HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_rpt
      $error("HOLD_CYC and REPEAT_CYC must be at least 1");
   end

   for (genvar k = 0; k < KEY_NUM; k++) begin : g_chan
      key_param_chan #(
         .PARAM_W      (PARAM_W),
         .PARAM_MAX    (PARAM_MAX),
         .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef KEY_REPEAT_EN
         ,
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
`endif
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .key_raw   (key_in[k]),
         .key_level (key_level[k]),
         .key_pulse (key_pulse[k]),
         .param     (param_arr[k])
      );
   end

   assign param_bus = param_arr;
endmodule

// File: tb/tb_key_param_ctrl.sv
// Directed bench for key_param_ctrl: debounce, pulse latency, wrap, parallel keys,
// auto-repeat (when KEY_REPEAT_EN is defined) and reset mid-hold.
module tb_key_param_ctrl;
   localparam int KN = 5;
   localparam int PW = 11;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [KN-1:0]    key_in = '0, key_in_w = '0;
   logic [KN-1:0]    key_level, key_pulse, key_level_w, key_pulse_w;
   logic [KN*PW-1:0] param_bus, param_bus_w;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   key_param_ctrl #(.KEY_NUM(KN), .PARAM_W(PW), .PARAM_MAX(100), .DEBOUNCE_CYC(4),
                    .HOLD_CYC(16), .REPEAT_CYC(4)) dut (
      .clk(clk), .reset_n(reset_n), .key_in(key_in),
      .key_level(key_level), .key_pulse(key_pulse), .param_bus(param_bus));

   key_param_ctrl #(.KEY_NUM(KN), .PARAM_W(PW), .PARAM_MAX(3), .DEBOUNCE_CYC(4),
                    .HOLD_CYC(16), .REPEAT_CYC(4)) dut_w (
      .clk(clk), .reset_n(reset_n), .key_in(key_in_w),
      .key_level(key_level_w), .key_pulse(key_pulse_w), .param_bus(param_bus_w));

   function automatic logic [PW-1:0] param_of(input logic [KN*PW-1:0] bus, input int k);
      return bus[k*PW +: PW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      key_in   = '0;
      key_in_w = '0;
      reset_n  = 1'b0;
      tick();
      tick();
      reset_n  = 1'b1;
   endtask

   task automatic test_reset();
      key_in  = '0;
      reset_n = 1'b0;
      #1;
      total++; if (key_level !== '0) begin bad++; $display("FAIL reset_level got=%b exp=0", key_level); end
      total++; if (key_pulse !== '0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", key_pulse); end
      total++; if (param_bus !== '0) begin bad++; $display("FAIL reset_param got=%h exp=0", param_bus); end
      total++; if (param_bus_w !== '0) begin bad++; $display("FAIL reset_param_w got=%h exp=0", param_bus_w); end
   endtask

   task automatic test_glitch();
      do_reset();
      key_in[0] = 1'b1;
      repeat (3) tick();
      key_in[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++; if (key_level[0] !== 1'b0 || key_pulse[0] !== 1'b0) begin
            bad++; $display("FAIL glitch_out cyc=%0d level=%b pulse=%b exp=0/0", i, key_level[0], key_pulse[0]);
         end
      end
      total++; if (param_of(param_bus, 0) !== 0) begin
         bad++; $display("FAIL glitch_param got=%0d exp=0", param_of(param_bus, 0));
      end
   endtask

   task automatic test_press();
      do_reset();
      key_in[0] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         total++; if (key_level[0] !== (i >= 6)) begin
            bad++; $display("FAIL press_level edge=%0d got=%b exp=%b", i, key_level[0], (i >= 6));
         end
         total++; if (key_pulse[0] !== (i == 7)) begin
            bad++; $display("FAIL press_pulse edge=%0d got=%b exp=%b", i, key_pulse[0], (i == 7));
         end
      end
      total++; if (param_of(param_bus, 0) !== 1) begin
         bad++; $display("FAIL press_param got=%0d exp=1", param_of(param_bus, 0));
      end
      key_in[0] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++; if (key_pulse[0] !== 1'b0) begin
            bad++; $display("FAIL release_pulse edge=%0d got=%b exp=0", i, key_pulse[0]);
         end
      end
      total++; if (key_level[0] !== 1'b0) begin bad++; $display("FAIL release_level got=%b exp=0", key_level[0]); end
      total++; if (param_of(param_bus, 0) !== 1) begin
         bad++; $display("FAIL release_param got=%0d exp=1", param_of(param_bus, 0));
      end
   endtask

   task automatic test_wrap();
      int exp_seq[5] = '{1, 2, 3, 0, 1};
      do_reset();
      for (int p = 0; p < 5; p++) begin
         key_in_w[2] = 1'b1;
         repeat (8) tick();
         total++; if (param_of(param_bus_w, 2) !== PW'(exp_seq[p])) begin
            bad++; $display("FAIL wrap_param press=%0d got=%0d exp=%0d", p + 1, param_of(param_bus_w, 2), exp_seq[p]);
         end
         key_in_w[2] = 1'b0;
         repeat (8) tick();
      end
   endtask

   task automatic test_simul();
      logic [KN*PW-1:0] exp_bus;
      exp_bus = '0;
      exp_bus[1*PW] = 1'b1;
      exp_bus[4*PW] = 1'b1;
      do_reset();
      key_in = 5'b10010;
      for (int i = 1; i <= 9; i++) begin
         tick();
         total++; if (key_pulse !== ((i == 7) ? 5'b10010 : 5'b00000)) begin
            bad++; $display("FAIL simul_pulse edge=%0d got=%b exp=%b", i, key_pulse, (i == 7) ? 5'b10010 : 5'b00000);
         end
      end
      total++; if (param_bus !== exp_bus) begin
         bad++; $display("FAIL simul_param got=%h exp=%h", param_bus, exp_bus);
      end
   endtask

   task automatic test_repeat();
      int npulse;
      do_reset();
      key_in[0] = 1'b1;
      repeat (7) tick();
      total++; if (key_pulse[0] !== 1'b1) begin bad++; $display("FAIL hold_first_pulse got=%b exp=1", key_pulse[0]); end
      npulse = 1;
      for (int j = 1; j <= 40; j++) begin
         logic exp_p;
         tick();
         // Dropping the key here lets key_level fall 30 cycles after the first pulse.
         if (j == 24) key_in[0] = 1'b0;
`ifdef KEY_REPEAT_EN
         exp_p = (j == 16 || j == 20 || j == 24 || j == 28);
`else
         exp_p = 1'b0;
`endif
         if (key_pulse[0]) npulse++;
         total++; if (key_pulse[0] !== exp_p) begin
            bad++; $display("FAIL hold_pulse offset=%0d got=%b exp=%b", j, key_pulse[0], exp_p);
         end
      end
`ifdef KEY_REPEAT_EN
      total++; if (param_of(param_bus, 0) !== 5 || npulse != 5) begin
         bad++; $display("FAIL repeat_param got=%0d pulses=%0d exp=5/5", param_of(param_bus, 0), npulse);
      end
`else
      total++; if (param_of(param_bus, 0) !== 1 || npulse != 1) begin
         bad++; $display("FAIL hold_param got=%0d pulses=%0d exp=1/1", param_of(param_bus, 0), npulse);
      end
`endif
   endtask

   task automatic test_reset_mid();
      logic [KN*PW-1:0] exp_bus;
      exp_bus = '0;
      exp_bus[3*PW] = 1'b1;
      do_reset();
      key_in[3] = 1'b1;
      repeat (8) tick();
      key_in[3] = 1'b0;
      repeat (8) tick();
      key_in[3] = 1'b1;
      repeat (8) tick();
      total++; if (param_of(param_bus, 3) !== 2 || key_level[3] !== 1'b1) begin
         bad++; $display("FAIL midrst_pre got=%0d level=%b exp=2/1", param_of(param_bus, 3), key_level[3]);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++; if (key_level !== '0 || key_pulse !== '0 || param_bus !== '0) begin
         bad++; $display("FAIL midrst_async level=%b pulse=%b param=%h exp=0", key_level, key_pulse, param_bus);
      end
      tick();
      reset_n = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++; if (key_pulse !== ((i == 7) ? 5'b01000 : 5'b00000)) begin
            bad++; $display("FAIL midrst_pulse edge=%0d got=%b exp=%b", i, key_pulse, (i == 7) ? 5'b01000 : 5'b00000);
         end
      end
      total++; if (param_bus !== exp_bus) begin
         bad++; $display("FAIL midrst_param got=%h exp=%h", param_bus, exp_bus);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_press();
      test_wrap();
      test_simul();
      test_repeat();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
